// File: rtl/moore_pkg.sv
// moore_pkg: shared symbol type and stimulus-generator state encoding for the moore X/Z interface
package moore_pkg;
  localparam int SYM_W = 2;
  typedef logic [SYM_W-1:0] sym_t;
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FINISH = 2'd2} state_t;
endpackage

// File: rtl/moore_pat_mem.sv
// moore_pat_mem: DEPTH x SYM_W pattern register file, async read, sync write, async clear
module moore_pat_mem
  import moore_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SYM_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SYM_W-1:0]         rdata
);
  sym_t mem [DEPTH];
  always_ff @(posedge CLK or posedge RST)
    if (RST) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/moore_stim_gen.sv
// moore_stim_gen: plays a loaded symbol pattern onto the moore detector's X input
// and counts Z rising edges seen while the pattern is being emitted.
module moore_stim_gen
  import moore_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HOLD  = 1,
  parameter int CW    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LOAD_EN,
  input  logic [$clog2(DEPTH)-1:0] LOAD_ADDR,
  input  logic [SYM_W-1:0]         LOAD_SYM,
  input  logic [$clog2(DEPTH):0]   LEN,
  input  logic                     REPEAT,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic                     Z_IN,
  output logic [SYM_W-1:0]         X,
  output logic                     X_VALID,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [CW-1:0]            HIT_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  state_t state;
  logic [AW-1:0] idx, last, raddr;
  logic [HW-1:0] hold;
  logic [AW:0] len_c;
  logic z_prev, hold_end, sym_end;
  sym_t rdata;
  assign len_c    = LEN > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : LEN;
  assign hold_end = hold == HW'(HOLD - 1);
  assign sym_end  = idx == last;
  // The single read port looks ahead to the next symbol, or to entry 0 on start/wrap
  assign raddr = (state == EMIT && hold_end && !sym_end) ? idx + AW'(1) : '0;
  moore_pat_mem #(.DEPTH(DEPTH)) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (LOAD_EN && !BUSY),
    .waddr (LOAD_ADDR),
    .wdata (LOAD_SYM),
    .raddr (raddr),
    .rdata (rdata)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state   <= IDLE;
      X       <= '0;
      X_VALID <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      HIT_CNT <= '0;
      z_prev  <= 1'b0;
      idx     <= '0;
      last    <= '0;
      hold    <= '0;
    end else begin
      z_prev <= Z_IN;
      DONE   <= 1'b0;
      case (state)
        IDLE:
          if (START && LEN != '0) begin
            state   <= EMIT;
            X       <= rdata;
            X_VALID <= 1'b1;
            BUSY    <= 1'b1;
            HIT_CNT <= '0;
            idx     <= '0;
            hold    <= '0;
            last    <= AW'(len_c - 1'b1);
          end
        EMIT:
          if (ABORT) begin
            state   <= IDLE;
            X       <= '0;
            X_VALID <= 1'b0;
            BUSY    <= 1'b0;
          end else begin
            if (Z_IN && !z_prev && HIT_CNT != '1) HIT_CNT <= HIT_CNT + 1'b1;
            hold <= hold_end ? '0 : hold + 1'b1;
            if (hold_end && !sym_end) begin
              idx <= idx + AW'(1);
              X   <= rdata;
            end else if (hold_end && REPEAT) begin
              idx <= '0;
              X   <= rdata;
            end else if (hold_end) begin
              state   <= FINISH;
              X       <= '0;
              X_VALID <= 1'b0;
              DONE    <= 1'b1;
            end
          end
        FINISH: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_moore_stim_gen.sv
// tb_moore_stim_gen: randomized playback scenarios on HOLD=1/CW=8 and HOLD=3/CW=2 instances
// sharing one stimulus stream, checked against a per-cycle trace model.
module tb_moore_stim_gen;
  localparam int D = 8, H2 = 3, CW2 = 2;
  logic CLK = 0, RST = 0, LOAD_EN = 0, REPEAT = 0, START = 0, ABORT = 0, Z_IN = 0;
  logic [2:0] LOAD_ADDR = '0;
  logic [1:0] LOAD_SYM = '0;
  logic [3:0] LEN = '0;
  logic [1:0] x1, x2;
  logic v1, v2, b1, b2, d1, d2;
  logic [7:0] h1;
  logic [1:0] h2;
  int checks = 0, errors = 0;
  logic [1:0] mem_m [D];
  bit zq [64];
  logic [12:0] rec [2][64];

  moore_stim_gen #(.DEPTH(D), .HOLD(1), .CW(8)) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_SYM(LOAD_SYM),
    .LEN(LEN), .REPEAT(REPEAT), .START(START), .ABORT(ABORT), .Z_IN(Z_IN),
    .X(x1), .X_VALID(v1), .BUSY(b1), .DONE(d1), .HIT_CNT(h1));
  moore_stim_gen #(.DEPTH(D), .HOLD(H2), .CW(CW2)) dut2 (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_SYM(LOAD_SYM),
    .LEN(LEN), .REPEAT(REPEAT), .START(START), .ABORT(ABORT), .Z_IN(Z_IN),
    .X(x2), .X_VALID(v2), .BUSY(b2), .DONE(d2), .HIT_CNT(h2));

  always #5 CLK = ~CLK;

  function automatic logic [12:0] obs(input int k);
    return k == 0 ? {x1, v1, b1, d1, h1} : {x2, v2, b2, d2, 8'(h2)};
  endfunction

  // Expected {X, X_VALID, BUSY, DONE, HIT_CNT} on cycle c after START
  function automatic logic [12:0] model(input int k, input int c, input int l, input bit rep, input int a);
    int hold = k == 0 ? 1 : H2;
    int sat = k == 0 ? 255 : (1 << CW2) - 1;
    int n = l * hold;
    int cnt = 0;
    logic [1:0] x = '0;
    bit v = 0, b = 0, d = 0;
    for (int i = 1; i < c; i++)
      if ((rep || i <= n) && (a == 0 || i < a) && zq[i] && !zq[i-1] && cnt < sat) cnt++;
    if (a == 0 || c <= a) begin
      if (rep || c <= n) begin
        x = mem_m[((c - 1) / hold) % l];
        v = 1;
        b = 1;
      end else if (c == n + 1) begin
        b = 1;
        d = 1;
      end
    end
    return {x, v, b, d, 8'(cnt)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int ad, input logic [1:0] s);
    LOAD_EN = 1; LOAD_ADDR = 3'(ad); LOAD_SYM = s;
    tick();
    LOAD_EN = 0;
    mem_m[ad] = s;
  endtask

  task automatic rand_z();
    for (int i = 0; i < 64; i++) zq[i] = 1'($urandom);
  endtask

  task automatic test_reset();
    RST = 1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 13'd0) begin
        errors++;
        $display("FAIL reset dut%0d got %b required %b", k, obs(k), 13'd0);
      end
    end
    RST = 0;
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    tick();
  endtask

  // Runs one playback; START/LOAD_EN/LEN noise is applied only while both instances are busy
  task automatic test_playback(input string nm, input int len, input bit rep, input int a, input int nc);
    int l = len > D ? D : len;
    int win = a != 0 ? a : l + 1;
    LEN = 4'(len); REPEAT = rep; Z_IN = zq[0]; START = 1;
    tick();
    START = 0;
    for (int c = 1; c <= nc; c++) begin
      rec[0][c] = obs(0);
      rec[1][c] = obs(1);
      ABORT = (c == a);
      Z_IN = zq[c];
      if (c <= win) begin
        START = 1'($urandom); LOAD_EN = 1'($urandom);
        LOAD_ADDR = 3'($urandom); LOAD_SYM = 2'($urandom); LEN = 4'($urandom);
      end else begin
        START = 0; LOAD_EN = 0;
      end
      tick();
    end
    START = 0; LOAD_EN = 0; ABORT = 0; Z_IN = 0;
    for (int k = 0; k < 2; k++)
      for (int c = 1; c <= nc; c++) begin
        checks++;
        if (rec[k][c] !== model(k, c, l, rep, a)) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d x_v_b_d_hit got %b required %b",
                   nm, k, c, rec[k][c], model(k, c, l, rep, a));
        end
      end
  endtask

  task automatic test_hit_pattern();
    bit zp [7] = '{0, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < 64; i++) zq[i] = i < 7 ? zp[i] : 1'b0;
    test_playback("hit_pattern", 8, 0, 0, 28);
    checks++;
    if (h1 !== 8'd2) begin
      errors++;
      $display("FAIL hit_pattern_count got %0d required 2", h1);
    end
  endtask

  task automatic test_len_zero();
    LEN = 0; START = 1;
    tick();
    START = 0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) >> 8 !== 13'd0) begin
          errors++;
          $display("FAIL len_zero dut%0d cycle %0d got %b required 00000", k, c, obs(k) >> 8);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int len, a, nc;
      bit rep;
      for (int i = 0; i < D; i++) load(i, 2'($urandom));
      rand_z();
      len = $urandom_range(1, 15);
      rep = 1'($urandom);
      if (rep) a = $urandom_range(2, 30);
      else a = $urandom_range(0, 2) == 0 ? $urandom_range(1, (len > D ? D : len) + 1) : 0;
      nc = rep ? a + 2 : 3 * (len > D ? D : len) + 4;
      test_playback("random", len, rep, a, nc);
    end
  endtask

  task automatic test_async_reset();
    load(0, 2'b11); load(1, 2'b10);
    LEN = 4; REPEAT = 0; START = 1;
    tick();
    START = 0;
    tick(); tick();
    #2 RST = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 13'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d got %b required %b", k, obs(k), 13'd0);
      end
    end
    #2 RST = 0;
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    tick();
    rand_z();
    test_playback("post_reset", 4, 0, 0, 16);
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 4; i++) load(i, 2'(i));
    rand_z();
    test_playback("basic", 4, 0, 0, 16);
    test_hit_pattern();
    load(0, 2'b01); load(1, 2'b10);
    rand_z();
    test_playback("repeat_abort", 2, 1, 7, 10);
    rand_z();
    test_playback("len_clamp", 15, 0, 0, 30);
    test_len_zero();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
